load_store_unit: RTL and testbench

Initiator side of the CPU's data-memory port: accepts one load or store request from the execute stage and drives the word-wide data memory (combinational read, write on rising clk). Supports byte, halfword and word accesses, with sign/zero extension on loads and read-modify-write merging for sub-word stores, because the memory only writes whole words. Sits between the ALU result/register-file read data and the data memory; the writeback mux consumes its response.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_byte_lane.sv | 36 +++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, lane constants and helpers for the load/store unit
package lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;
    localparam int LSU_BYTE_W     = 8;
    localparam int LSU_HALF_W     = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_MERGE_WR,
        ST_RESP
    } lsu_state_e;

    // The reserved size encoding behaves exactly like a word access.
    function automatic lsu_size_e lsu_decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - combinational lane extract/extend for loads and lane merge for stores
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  lsu_size_e                 size_i,
    input  logic                      unsigned_i,
    input  logic [1:0]                addr_lo_i,
    input  logic [LSU_DATA_WIDTH-1:0] rd_i,
    input  logic [LSU_DATA_WIDTH-1:0] wdata_i,
    output logic [LSU_DATA_WIDTH-1:0] ld_data_o,
    output logic [LSU_DATA_WIDTH-1:0] st_merged_o
);

    logic [LSU_BYTE_W-1:0] byte_sel;
    logic [LSU_HALF_W-1:0] half_sel;

    always_comb begin
        byte_sel = rd_i[{addr_lo_i, 3'b000} +: LSU_BYTE_W];
        half_sel = rd_i[{addr_lo_i[1], 4'b0000} +: LSU_HALF_W];

        case (size_i)
            SZ_BYTE: ld_data_o = {{(LSU_DATA_WIDTH-LSU_BYTE_W){~unsigned_i & byte_sel[LSU_BYTE_W-1]}}, byte_sel};
            SZ_HALF: ld_data_o = {{(LSU_DATA_WIDTH-LSU_HALF_W){~unsigned_i & half_sel[LSU_HALF_W-1]}}, half_sel};
            default: ld_data_o = rd_i;
        endcase

        // Sub-word stores overwrite only their lane(s) of the word just read.
        st_merged_o = rd_i;
        case (size_i)
            SZ_BYTE: st_merged_o[{addr_lo_i, 3'b000} +: LSU_BYTE_W]    = wdata_i[LSU_BYTE_W-1:0];
            SZ_HALF: st_merged_o[{addr_lo_i[1], 4'b0000} +: LSU_HALF_W] = wdata_i[LSU_HALF_W-1:0];
            default: st_merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator with sub-word read-modify-write
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = LSU_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    lsu_state_e               state_q;
    logic                     we_q;
    logic                     unsigned_q;
    lsu_size_e                size_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     resp_valid_q;
    logic [DATA_WIDTH-1:0]    resp_rdata_q;
    logic                     resp_err_q;
    logic                     mem_wr_en_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_wd_q;

    lsu_size_e             req_size_d;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] st_merged;

    assign req_size_d = lsu_decode_size(req_size);

    lsu_byte_lane u_lane (
        .size_i      (size_q),
        .unsigned_i  (unsigned_q),
        .addr_lo_i   (addr_q[1:0]),
        .rd_i        (mem_rd),
        .wdata_i     (wdata_q),
        .ld_data_o   (ld_data),
        .st_merged_o (st_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= SZ_BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
        end else begin
            // The response is a single-cycle pulse; rdata reads as 0 outside it.
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size_d;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        mem_addr_q <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
                        if (lsu_misaligned(req_size_d, req_addr[1:0])) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else
`endif
                        begin
                            state_q <= ST_ACCESS;
                            if (req_we && req_size_d == SZ_WORD) begin
                                mem_wr_en_q <= 1'b1;
                                mem_wd_q    <= req_wdata;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        resp_rdata_q <= ld_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (size_q == SZ_WORD) begin
                        mem_wr_en_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        mem_wd_q    <= st_merged;
                        mem_wr_en_q <= 1'b1;
                        state_q     <= ST_MERGE_WR;
                    end
                end
                ST_MERGE_WR: begin
                    mem_wr_en_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a word-wide memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] wd;
    } op_t;

    op_t sb_q[$];

    logic        obs_got, obs_err, obs_ready, obs_busy;
    logic [31:0] obs_rdata, obs_wa, obs_wd;
    int          obs_lat, obs_nwr;

    logic [31:0] ref_mem [0:7];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_wr_en) mem[mem_addr[11:2]] <= mem_wd;
    assign mem_rd = mem[mem_addr[11:2]];

    load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    function automatic op_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic err, input int lat,
                               input int nwr, input logic [31:0] wd);
        op_t o;
        o.we = we; o.size = size; o.uns = uns; o.addr = addr; o.wdata = wdata;
        o.rdata = rdata; o.err = err; o.lat = lat; o.nwr = nwr; o.wd = wd;
        return o;
    endfunction

    // Push the expectation, drive one request, then watch the bus until the response.
    task automatic issue(input op_t op);
        sb_q.push_back(op);
        @(negedge clk);
        obs_ready = req_ready;
        req_valid = 1'b1; req_we = op.we; req_size = op.size; req_unsigned = op.uns;
        req_addr = op.addr; req_wdata = op.wdata;
        obs_got = 1'b0; obs_nwr = 0; obs_lat = 0; obs_rdata = '0; obs_err = 1'b0;
        obs_wa = '0; obs_wd = '0; obs_busy = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 8 && !obs_got; c++) begin
            @(negedge clk);
            if (req_ready) obs_busy = 1'b1;
            if (mem_wr_en) begin obs_nwr++; obs_wa = mem_addr; obs_wd = mem_wd; end
            if (resp_valid) begin
                obs_got = 1'b1; obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err;
            end else begin
                @(posedge clk);
            end
        end
    endtask

    task automatic test_reset;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset resp_rdata got %h exp 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset resp_err got %b exp 0", resp_err); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset mem_wr_en got %b exp 0", mem_wr_en); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL reset mem_wd got %h exp 0", mem_wd); end
    endtask

    task automatic test_table(input string name, input op_t ops[$]);
        op_t e;
        foreach (ops[i]) begin
            issue(ops[i]);
            e = sb_q.pop_front();
            checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL %s[%0d] ready at issue got %b exp 1", name, i, obs_ready); end
            checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL %s[%0d] req_ready while busy got 1 exp 0", name, i); end
            checks++;
            if (!obs_got) begin
                errors++; $display("FAIL %s[%0d] response timeout got none exp resp_valid", name, i);
            end else begin
                checks++; if (obs_lat != e.lat) begin errors++; $display("FAIL %s[%0d] latency got %0d exp %0d", name, i, obs_lat, e.lat); end
                checks++; if (obs_rdata !== e.rdata) begin errors++; $display("FAIL %s[%0d] rdata got %h exp %h", name, i, obs_rdata, e.rdata); end
                checks++; if (obs_err !== e.err) begin errors++; $display("FAIL %s[%0d] err got %b exp %b", name, i, obs_err, e.err); end
            end
            checks++; if (obs_nwr != e.nwr) begin errors++; $display("FAIL %s[%0d] write count got %0d exp %0d", name, i, obs_nwr, e.nwr); end
            if (e.nwr > 0) begin
                checks++; if (obs_wa !== {e.addr[31:2], 2'b00}) begin errors++; $display("FAIL %s[%0d] write addr got %h exp %h", name, i, obs_wa, {e.addr[31:2], 2'b00}); end
                checks++; if (obs_wd !== e.wd) begin errors++; $display("FAIL %s[%0d] write data got %h exp %h", name, i, obs_wd, e.wd); end
            end
        end
    endtask

    task automatic test_word;
        op_t t[$];
        t.push_back(mk(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF));
        t.push_back(mk(0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0));
        test_table("word", t);
    endtask

    task automatic test_load_ext;
        op_t t[$];
        t.push_back(mk(1, 2'b10, 0, 32'h0FC, 32'h12345680, 32'h0,        0, 2, 1, 32'h12345680));
        t.push_back(mk(0, 2'b00, 0, 32'h0FC, 32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b00, 1, 32'h0FC, 32'h0,        32'h00000080, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b01, 1, 32'h0FE, 32'h0,        32'h00001234, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b01, 0, 32'h0FC, 32'h0,        32'h00005680, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b00, 0, 32'h0FF, 32'h0,        32'h00000012, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b00, 1, 32'h0FD, 32'h0,        32'h00000056, 0, 2, 0, 32'h0));
        test_table("load_ext", t);
    endtask

    task automatic test_subword_store;
        op_t t[$];
        t.push_back(mk(1, 2'b00, 0, 32'h0FD, 32'h123456AA, 32'h0,        0, 3, 1, 32'h1234AA80));
        t.push_back(mk(0, 2'b10, 0, 32'h0FC, 32'h0,        32'h1234AA80, 0, 2, 0, 32'h0));
        t.push_back(mk(1, 2'b01, 0, 32'h0FE, 32'h5555BEEF, 32'h0,        0, 3, 1, 32'hBEEFAA80));
        t.push_back(mk(0, 2'b01, 0, 32'h0FE, 32'h0,        32'hFFFFBEEF, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b11, 0, 32'h0FC, 32'h0,        32'hBEEFAA80, 0, 2, 0, 32'h0));
        test_table("subword", t);
    endtask

    task automatic test_misalign;
        op_t t[$];
`ifdef LSU_MISALIGN_TRAP_EN
        t.push_back(mk(0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        1, 1, 0, 32'h0));
        t.push_back(mk(0, 2'b01, 0, 32'h101, 32'h0,        32'h0,        1, 1, 0, 32'h0));
        t.push_back(mk(1, 2'b10, 0, 32'h102, 32'h11111111, 32'h0,        1, 1, 0, 32'h0));
        t.push_back(mk(0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b01, 1, 32'h102, 32'h0,        32'h0000DEAD, 0, 2, 0, 32'h0));
`else
        t.push_back(mk(0, 2'b10, 0, 32'h101, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b01, 0, 32'h101, 32'h0,        32'hFFFFBEEF, 0, 2, 0, 32'h0));
        t.push_back(mk(1, 2'b10, 0, 32'h102, 32'h11111111, 32'h0,        0, 2, 1, 32'h11111111));
        t.push_back(mk(0, 2'b10, 0, 32'h100, 32'h0,        32'h11111111, 0, 2, 0, 32'h0));
        t.push_back(mk(0, 2'b01, 1, 32'h102, 32'h0,        32'h00001111, 0, 2, 0, 32'h0));
`endif
        test_table("misalign", t);
    endtask

    task automatic test_reset_mid;
        bit saw_resp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0FC; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL rst_mid write phase mem_wr_en got %b exp 1", mem_wr_en); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid mem_wr_en got %b exp 0", mem_wr_en); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid resp_valid got %b exp 0", resp_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem[10'h03F] !== 32'hBEEFAA80) begin errors++; $display("FAIL rst_mid memory got %h exp %h", mem[10'h03F], 32'hBEEFAA80); end
        rst_n = 1'b1;
        saw_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL rst_mid stray resp_valid got 1 exp 0"); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid req_ready got %b exp 1", req_ready); end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic u, input logic [1:0] a);
        logic [31:0] s;
        if (sz == 2'b00) begin
            s = w >> {a, 3'b000};
            return u ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        end else if (sz == 2'b01) begin
            s = a[1] ? (w >> 16) : w;
            return u ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        end
        return w;
    endfunction

    task automatic test_back_to_back;
        op_t t[$];
        op_t o;
        logic [31:0] mask, shd;
        logic [1:0]  sz, lo;
        int          idx;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            t.push_back(mk(1, 2'b10, 0, 32'h200 + 32'(4*i), ref_mem[i], 32'h0, 0, 2, 1, ref_mem[i]));
        end
        for (int i = 0; i < 20; i++) begin
            idx = $urandom_range(7, 0);
            sz  = 2'($urandom_range(2, 0));
            lo  = 2'($urandom);
            if (sz == 2'b01) lo[0] = 1'b0;
            if (sz == 2'b10) lo = 2'b00;
            o = mk(1'($urandom), sz, 1'($urandom), 32'h200 + 32'(4*idx) + 32'(lo), $urandom, 32'h0, 0, 2, 0, 32'h0);
            if (o.we) begin
                mask = (sz == 2'b00) ? (32'h000000FF << {lo, 3'b000}) :
                       (sz == 2'b01) ? (32'h0000FFFF << {lo[1], 4'b0000}) : 32'hFFFFFFFF;
                shd  = (sz == 2'b00) ? (o.wdata << {lo, 3'b000}) :
                       (sz == 2'b01) ? (o.wdata << {lo[1], 4'b0000}) : o.wdata;
                ref_mem[idx] = (ref_mem[idx] & ~mask) | (shd & mask);
                o.nwr = 1; o.wd = ref_mem[idx];
                o.lat = (sz == 2'b10) ? 2 : 3;
            end else begin
                o.rdata = ref_load(ref_mem[idx], sz, o.uns, lo);
            end
            t.push_back(o);
        end
        test_table("b2b", t);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_word();
        test_load_ext();
        test_subword_store();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
